// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the instruction byte loader
// Purpose: frame markers, IMEM geometry and the loader FSM state encoding.
// Ports: none (package).
package cpu_pkg;

  localparam int DEPTH_WORDS = 64;
  localparam int ADDR_W      = $clog2(DEPTH_WORDS);
  localparam int WORD_W      = 32;

  localparam logic [7:0] START_BYTE = 8'hFE;
  localparam logic [7:0] END_BYTE   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - 8->32 MSB-first shift packer with in-word byte position
// Purpose: collects stream bytes into 32-bit words; flags the cycle holding the 4th byte.
// Ports:
//   clk_i        in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   shift_en_i   in   accept byte_i this cycle
//   byte_i       in   data byte
//   byte_cnt_o   out  position of byte_i inside the current word (0..3)
//   word_valid_o out  byte_i completes a word this cycle
//   word_o       out  completed word {three earlier bytes, byte_i}
module byte_packer
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset,
  input  logic              shift_en_i,
  input  logic [7:0]        byte_i,
  output logic [1:0]        byte_cnt_o,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o
);

  logic [23:0] shift_q;
  logic [1:0]  byte_cnt_q;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else if (shift_en_i) begin
      shift_q    <= {shift_q[15:0], byte_i};
      byte_cnt_q <= byte_cnt_q + 2'd1;   // wraps 3 -> 0 at word boundary
    end
  end

  assign byte_cnt_o   = byte_cnt_q;
  assign word_valid_o = shift_en_i && (byte_cnt_q == 2'd3);
  assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/instr_byte_loader.sv
// rtl/instr_byte_loader.sv - framed byte stream to 32-bit IMEM word loader
// Purpose: waits for the start marker, packs bytes into words written to IMEM,
//   stops on the end marker (at a word boundary) or when IMEM is full, then
//   pulses cpu_start once and holds load_done until reset.
// Ports:
//   clk_i       in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   instr_i     in   stream byte, registered every clock
//   imem_we     out  IMEM write strobe, one cycle per word
//   imem_addr   out  IMEM word address
//   imem_wdata  out  packed word, first byte in [31:24]
//   word_count  out  words written so far
//   load_done   out  program loaded (level)
//   load_full   out  IMEM filled before the end marker (level)
//   cpu_start   out  one-cycle pulse on entry to DONE
module instr_byte_loader
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset,
  input  logic [7:0]        instr_i,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              load_full,
  output logic              cpu_start
);

  localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W+1)'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH_WORDS - 1);

  loader_state_t state_q, state_d;

  logic [7:0]        byte_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [WORD_W-1:0] imem_wdata_q;
  logic [ADDR_W:0]   word_count_q;
  logic              load_done_q, load_done_d;
  logic              load_full_q, load_full_d;
  logic              cpu_start_q, cpu_start_d;

  logic              shift_en;
  logic [1:0]        byte_cnt;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic              end_at_boundary;
  logic              last_word;

  // Input register: the FSM and packer only ever see byte_q, so no output
  // depends combinationally on instr_i.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) byte_q <= '0;
    else       byte_q <= instr_i;
  end

  byte_packer u_packer (
    .clk_i        (clk_i),
    .reset        (reset),
    .shift_en_i   (shift_en),
    .byte_i       (byte_q),
    .byte_cnt_o   (byte_cnt),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // An end marker only terminates at a word boundary; mid-word it is data.
  assign end_at_boundary = (byte_cnt == 2'd0) && (byte_q == END_BYTE);
  // Previous write has always retired by the time the next word completes,
  // so word_count_q already counts every earlier word here.
  assign last_word       = word_valid && (word_count_q == LAST_COUNT);

  // State register
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (byte_q == START_BYTE) state_d = LOAD;
      LOAD: if (end_at_boundary || last_word) state_d = DONE;
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic (next values of the registered flags)
  always_comb begin
    shift_en    = (state_q == LOAD) && !end_at_boundary;
    load_done_d = (state_d == DONE);
    cpu_start_d = (state_d == DONE) && (state_q != DONE);
    load_full_d = load_full_q || ((state_q == LOAD) && last_word);
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      word_count_q <= '0;
      load_done_q  <= 1'b0;
      load_full_q  <= 1'b0;
      cpu_start_q  <= 1'b0;
    end else begin
      imem_we_q   <= word_valid;
      load_done_q <= load_done_d;
      load_full_q <= load_full_d;
      cpu_start_q <= cpu_start_d;
      if (word_valid) imem_wdata_q <= word;
      // Address/count advance once the write cycle has been presented to IMEM.
      if (imem_we_q) begin
        word_count_q <= word_count_q + 1'b1;
        if (imem_addr_q != LAST_ADDR) imem_addr_q <= imem_addr_q + 1'b1;
      end
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_count = word_count_q;
  assign load_done  = load_done_q;
  assign load_full  = load_full_q;
  assign cpu_start  = cpu_start_q;

endmodule
